// File: rtl/tbman_regs.sv
`default_nettype none
// ============================================================================
// tbman_regs : testbench-manager register page (exit, putc FIFO, status,
//              cycle counter, watchdog timeout, scratch)
// Revision   : 1.0
// ============================================================================
module tbman_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_n,
   input  logic        we,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        putc_valid,
   output logic [7:0]  putc_data,
   input  logic        putc_ready,
   output logic        sim_done,
   output logic        sim_pass,
   output logic [31:0] exit_code
);

   localparam logic [9:0]  c_ofs_exit    = 10'h000;
   localparam logic [9:0]  c_ofs_putc    = 10'h001;
   localparam logic [9:0]  c_ofs_status  = 10'h002;
   localparam logic [9:0]  c_ofs_cycle   = 10'h003;
   localparam logic [9:0]  c_ofs_timeout = 10'h004;
   localparam logic [9:0]  c_ofs_scratch = 10'h005;
   localparam logic [31:0] c_wd_code     = 32'hDEAD_0001;
   localparam logic [3:0]  c_depth       = 4'd8;

   logic [7:0]  fifo_q [0:7];
   logic [7:0]  fifo_d [0:7];
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]  count_q, count_d;
   logic        ovf_q, ovf_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] exit_q, exit_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] timeout_q, timeout_d;
   logic [31:0] scratch_q, scratch_d;

   logic [9:0]  w_word;
   logic        w_wr;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_push_req;
   logic        w_push;
   logic        w_ovf_set;
   logic        w_ovf_clr;
   logic        w_exit_wr;
   logic        w_wd_fire;
   logic        w_unused_addr;

   assign w_word        = addr[11:2];
   assign w_unused_addr = ^addr[1:0];
   assign w_wr          = !cs_n && we;
   assign w_full        = (count_q == c_depth);
   assign w_empty       = (count_q == 4'd0);
   assign w_pop         = !w_empty && putc_ready;
   assign w_push_req    = w_wr && (w_word == c_ofs_putc);
   // A full FIFO still takes the byte when the head leaves on the same edge.
   assign w_push        = w_push_req && (!w_full || w_pop);
   assign w_ovf_set     = w_push_req && w_full && !w_pop;
   assign w_ovf_clr     = w_wr && (w_word == c_ofs_status) && wdata[8];
   assign w_exit_wr     = w_wr && (w_word == c_ofs_exit) && !done_q;
   assign w_wd_fire     = (timeout_q != 32'd0) && !done_q && (cycle_q == timeout_q);

   assign putc_valid = !w_empty;
   assign putc_data  = fifo_q[rd_ptr_q];
   assign sim_done   = done_q;
   assign sim_pass   = pass_q;
   assign exit_code  = exit_q;

   always_comb begin
      rdata = 32'd0;
      if (!cs_n) begin
         case (w_word)
            c_ofs_status:  rdata = {23'd0, ovf_q, count_q, w_full, w_empty, pass_q, done_q};
            c_ofs_cycle:   rdata = cycle_q;
            c_ofs_timeout: rdata = timeout_q;
            c_ofs_scratch: rdata = scratch_q;
            default:       rdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      done_d    = done_q;
      pass_d    = pass_q;
      exit_d    = exit_q;
      cycle_d   = cycle_q;
      timeout_d = timeout_q;
      scratch_d = scratch_q;

      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 3'd1;
      end
      if (w_push) begin
         fifo_d[wr_ptr_q] = wdata[7:0];
         wr_ptr_d         = wr_ptr_q + 3'd1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase

      // Set dominates clear so a coincident overflow is never lost.
      if (w_ovf_set) begin
         ovf_d = 1'b1;
      end else if (w_ovf_clr) begin
         ovf_d = 1'b0;
      end

      if (w_exit_wr) begin
         done_d = 1'b1;
         pass_d = (wdata == 32'd0);
         exit_d = wdata;
      end else if (w_wd_fire) begin
         done_d = 1'b1;
         pass_d = 1'b0;
         exit_d = c_wd_code;
      end

      // Holding on expiry leaves CYCLE reading exactly the timeout value.
      if (!done_q && !w_wd_fire) begin
         cycle_d = cycle_q + 32'd1;
      end

      if (w_wr && (w_word == c_ofs_timeout)) begin
         timeout_d = wdata;
      end
      if (w_wr && (w_word == c_ofs_scratch)) begin
         scratch_d = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            fifo_q[i] <= 8'd0;
         end
         wr_ptr_q  <= 3'd0;
         rd_ptr_q  <= 3'd0;
         count_q   <= 4'd0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         exit_q    <= 32'd0;
         cycle_q   <= 32'd0;
         timeout_q <= 32'd0;
         scratch_q <= 32'd0;
      end else begin
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         exit_q    <= exit_d;
         cycle_q   <= cycle_d;
         timeout_q <= timeout_d;
         scratch_q <= scratch_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tbman_regs.sv
`default_nettype none
// ============================================================================
// tb_tbman_regs : self-checking bench for tbman_regs against a queue model
// Revision      : 1.0
// ============================================================================
module tb_tbman_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_n;
   logic        we;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        putc_valid;
   logic [7:0]  putc_data;
   logic        putc_ready;
   logic        sim_done;
   logic        sim_pass;
   logic [31:0] exit_code;

   tbman_regs dut (
      .clk        (clk),
      .reset      (reset),
      .cs_n       (cs_n),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .putc_valid (putc_valid),
      .putc_data  (putc_data),
      .putc_ready (putc_ready),
      .sim_done   (sim_done),
      .sim_pass   (sim_pass),
      .exit_code  (exit_code)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0]  m_fifo [$];
   logic [7:0]  got [$];
   logic        m_ovf, m_done, m_pass;
   logic [31:0] m_exit, m_cycle, m_timeout, m_scratch;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      int n = m_fifo.size();
      case (a[11:2])
         10'd2:   return {23'd0, m_ovf, 4'(n), 1'(n == 8), 1'(n == 0), m_pass, m_done};
         10'd3:   return m_cycle;
         10'd4:   return m_timeout;
         10'd5:   return m_scratch;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_clear();
      m_fifo.delete();
      m_ovf = 0; m_done = 0; m_pass = 0;
      m_exit = 0; m_cycle = 0; m_timeout = 0; m_scratch = 0;
   endtask

   task automatic model_edge(input bit c, input bit w, input logic [11:0] a,
                             input logic [31:0] d, input bit rdy);
      bit wr    = !c && w;
      int n     = m_fifo.size();
      bit pop   = rdy && (n > 0);
      bit wd    = (m_timeout != 0) && !m_done && (m_cycle == m_timeout);
      bit done0 = m_done;
      bit oset  = 0;
      logic [7:0] dummy;
      if (pop) dummy = m_fifo.pop_front();
      if (wr && a[11:2] == 10'd1) begin
         if (n < 8 || pop) m_fifo.push_back(d[7:0]);
         else oset = 1;
      end
      if (oset) m_ovf = 1;
      else if (wr && a[11:2] == 10'd2 && d[8]) m_ovf = 0;
      if (wr && a[11:2] == 10'd0 && !done0) begin
         m_done = 1; m_pass = (d == 0); m_exit = d;
      end else if (wd) begin
         m_done = 1; m_pass = 0; m_exit = 32'hDEAD0001;
      end
      if (!done0 && !wd) m_cycle = m_cycle + 1;
      if (wr && a[11:2] == 10'd4) m_timeout = d;
      if (wr && a[11:2] == 10'd5) m_scratch = d;
   endtask

   // One clock: drive, check outputs against the model, advance both.
   task automatic cyc(input bit c, input bit w, input logic [11:0] a,
                      input logic [31:0] d, input bit rdy);
      cs_n = c; we = w; addr = a; wdata = d; putc_ready = rdy;
      #1;
      check_eq("rdata", rdata, c ? 32'd0 : m_read(a));
      check_eq("putc_valid", 32'(putc_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) check_eq("putc_data", 32'(putc_data), 32'(m_fifo[0]));
      check_eq("done_pass", 32'({sim_done, sim_pass}), 32'({m_done, m_pass}));
      check_eq("exit_code", exit_code, m_exit);
      if (putc_valid && rdy) got.push_back(putc_data);
      model_edge(c, w, a, d, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input logic [11:0] a, input logic [31:0] exp, input string tag);
      cs_n = 0; we = 0; addr = a;
      #1;
      check_eq(tag, rdata, exp);
   endtask

   task automatic do_reset();
      reset = 1; cs_n = 0; we = 0; addr = 12'h008; wdata = 0; putc_ready = 0;
      #1;
      model_clear();
      check_eq("rst_valid", 32'(putc_valid), 32'd0);
      check_eq("rst_status", rdata, 32'h4);
      check_eq("rst_exit", exit_code, 32'd0);
      @(posedge clk);
      addr = 12'h00C;
      #1;
      check_eq("rst_cycle", rdata, 32'd0);
      @(negedge clk);
      reset = 0;
      #1;
   endtask

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      bit          c, w;
      reset = 1; cs_n = 1; we = 0; addr = 0; wdata = 0; putc_ready = 0;
      do_reset();

      // Decode: unmapped, deselected, scratch round trip
      cyc(0, 0, 12'h00C, 0, 0);
      cyc(0, 1, 12'h014, 32'hA5A5A5A5, 0);
      rd_check(12'h014, 32'hA5A5A5A5, "scratch");
      rd_check(12'h017, 32'hA5A5A5A5, "scratch_lowbits");
      rd_check(12'h020, 32'd0, "unmapped");
      cs_n = 1; addr = 12'h014; #1;
      check_eq("deselected", rdata, 32'd0);
      cyc(0, 1, 12'h020, 32'h12345678, 0);

      // Overflow: nine pushes with ready low
      for (int i = 0; i < 9; i++) cyc(0, 1, 12'h004, 32'h41 + 32'(i), 0);
      rd_check(12'h008, 32'h188, "status_full_ovf");
      got.delete();
      for (int i = 0; i < 12; i++) cyc(1, 0, 12'h000, 0, 1);
      check_eq("drain_len", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         check_eq("drain_byte", 32'(got[i]), 32'h41 + 32'(i));
      cyc(0, 1, 12'h008, 32'h100, 0);
      rd_check(12'h008, 32'h4, "ovf_cleared");

      // Streaming with ready high, then push+pop on a full FIFO
      for (int i = 0; i < 20; i++) cyc(0, 1, 12'h004, 32'h41, 1);
      rd_check(12'h008, 32'h10, "stream_count1");
      for (int i = 0; i < 7; i++) cyc(0, 1, 12'h004, 32'h50 + 32'(i), 0);
      rd_check(12'h008, 32'h88, "full8");
      cyc(0, 1, 12'h004, 32'h42, 1);
      rd_check(12'h008, 32'h88, "full_pushpop");
      for (int i = 0; i < 10; i++) cyc(1, 0, 12'h000, 0, 1);

      // EXIT=0, then a later EXIT is ignored; PUTC still accepted
      cyc(0, 1, 12'h000, 32'd0, 0);
      check_eq("exit0_flags", 32'({sim_done, sim_pass}), 32'h3);
      cyc(0, 1, 12'h000, 32'd5, 0);
      check_eq("exit_sticky", exit_code, 32'd0);
      cyc(0, 1, 12'h004, 32'h5A, 0);
      rd_check(12'h008, 32'h13, "putc_after_done");

      // Reset mid-drain
      cyc(1, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 1, 12'h004, 32'h61 + 32'(i), 0);
      cyc(1, 0, 0, 0, 1);
      do_reset();

      // Watchdog
      for (int i = 0; i < 50 && m_cycle < 10; i++) cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 12'h010, 32'd100, 0);
      for (int i = 0; i < 200 && !sim_done; i++) cyc(1, 0, 0, 0, 0);
      check_eq("wd_flags", 32'({sim_done, sim_pass}), 32'h2);
      check_eq("wd_code", exit_code, 32'hDEAD0001);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
      rd_check(12'h00C, 32'd100, "cycle_frozen");

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         c = ($urandom_range(0, 3) == 0);
         w = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0: a = 12'h000;
            1: a = 12'h004;
            2: a = 12'h008;
            3: a = 12'h00C;
            4: a = 12'h010;
            5: a = 12'h014;
            6: a = 12'h020;
            default: a = 12'h004;
         endcase
         if (a == 12'h000 && $urandom_range(0, 15) != 0) a = 12'h004;
         a[1:0] = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a[11:2] == 10'd4) d = $urandom_range(0, 400);
         cyc(c, w, a, d, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
